result_reader: RTL and testbench

Consumer-side block for the datapath's output register. It watches the `LD_outr` strobe alongside `main`, captures each new `outr` value one cycle after the strobe (once the register has updated), and buffers the values in a small show-ahead FIFO. Results drain through a valid/ready handshake, so a host or testbench can read every result the datapath writes. A sticky overflow flag and a capture counter are provided for verification.

---
 rtl/result_reader.sv | 73 +++++++
 tb/tb_result_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/result_reader.sv
// Consumer-side capture of the datapath output register into a show-ahead FIFO.
// Each LD_outr strobe arms a capture of the post-load outr value on the next edge.
module result_reader #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     E,
  input  logic                     LD_outr,
  input  logic [WIDTH-1:0]         outr,
  input  logic                     res_ready,
  input  logic                     clr_ovf,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  output logic [7:0]               total
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pend;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic [LW-1:0]    level_next;

  assign full = (level == LW'(DEPTH));
  assign pop  = res_valid & res_ready;
  // A full FIFO still accepts a capture when the head leaves on the same edge.
  assign push = pend & (~full | pop);
  assign drop = pend & full & ~pop;

  always_comb begin
    level_next = level + LW'(push) - LW'(pop);
  end

  assign res_data = res_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= outr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      res_valid <= 1'b0;
      ovf       <= 1'b0;
      total     <= '0;
    end else begin
      pend <= E & LD_outr;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        total  <= total + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      level     <= level_next;
      res_valid <= (level_next != '0);
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor checks every presented head entry.
module tb_result_reader;

  logic       clk = 1'b0;
  logic       rst, E, LD_outr, res_ready, clr_ovf;
  logic [3:0] outr, nxt;
  logic       res_valid;
  logic [3:0] res_data;
  logic [2:0] level;
  logic       ovf;
  logic [7:0] total;

  logic [3:0] exp_q[$];
  int unsigned checks = 0;
  int unsigned fails  = 0;

  result_reader #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .E(E), .LD_outr(LD_outr), .outr(outr),
    .res_ready(res_ready), .clr_ovf(clr_ovf), .res_valid(res_valid),
    .res_data(res_data), .level(level), .ovf(ovf), .total(total)
  );

  always #5 clk = ~clk;

  // Datapath output register: loads nxt whenever LD_outr is sampled high.
  always @(posedge clk) if (LD_outr) outr <= nxt;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: whenever a result is presented, it must match the scoreboard head.
  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL mon_unexpected: got data %0d, expected no valid result", res_data);
      end else begin
        if (res_data !== exp_q[0]) begin
          fails++;
          $display("FAIL mon_data: got %0d, expected %0d", res_data, exp_q[0]);
        end
        if (res_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; E = 1'b0; LD_outr = 1'b0; res_ready = 1'b0; clr_ovf = 1'b0;
    nxt = 4'h0; outr = 4'h0;
    do_reset();
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_total", total, 0);

    // Single capture: strobe at edge k, result visible after edge k+1.
    E = 1'b1; LD_outr = 1'b1; nxt = 4'hA; exp_q.push_back(4'hA);
    tick();
    LD_outr = 1'b0;
    check("single_not_yet", res_valid, 0);
    tick();
    check("single_valid", res_valid, 1);
    check("single_data", res_data, 10);
    check("single_level", level, 1);
    check("single_total", total, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("single_pop_valid", res_valid, 0);
    check("single_pop_data", res_data, 0);
    check("single_pop_level", level, 0);

    // Enable gating.
    E = 1'b0; LD_outr = 1'b1; nxt = 4'h7;
    tick();
    LD_outr = 1'b0;
    tick(); tick();
    check("gate_level", level, 0);
    check("gate_total", total, 1);
    E = 1'b1;

    // Burst of five into a 4-deep FIFO: fifth is dropped.
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      nxt = 4'(v); LD_outr = 1'b1;
      if (v <= 4) exp_q.push_back(4'(v));
      tick();
    end
    LD_outr = 1'b0;
    tick();
    check("burst_level", level, 4);
    check("burst_ovf", ovf, 1);
    check("burst_total", total, 4);
    res_ready = 1'b1;
    repeat (4) tick();
    res_ready = 1'b0;
    check("burst_drained", level, 0);
    check("burst_ovf_sticky", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("burst_ovf_clr", ovf, 0);

    // Full FIFO with simultaneous push and pop, draining across the wrap.
    do_reset();
    for (int v = 1; v <= 4; v++) begin
      nxt = 4'(v); LD_outr = 1'b1; exp_q.push_back(4'(v));
      tick();
    end
    LD_outr = 1'b0;
    tick();
    check("full_level", level, 4);
    nxt = 4'd5; LD_outr = 1'b1; exp_q.push_back(4'd5);
    tick();
    res_ready = 1'b1;
    nxt = 4'd6; exp_q.push_back(4'd6);
    tick();
    check("full_pp_level1", level, 4);
    LD_outr = 1'b0;
    tick();
    check("full_pp_level2", level, 4);
    check("full_pp_ovf", ovf, 0);
    repeat (4) tick();
    res_ready = 1'b0;
    check("full_drained", level, 0);
    check("full_total", total, 6);

    // Reset with a pending capture and two queued entries.
    do_reset();
    nxt = 4'd3; LD_outr = 1'b1; exp_q.push_back(4'd3);
    tick();
    nxt = 4'd9; exp_q.push_back(4'd9);
    tick();
    LD_outr = 1'b0;
    tick();
    check("mid_level", level, 2);
    nxt = 4'hC; LD_outr = 1'b1;
    tick();
    LD_outr = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_total", total, 0);
    repeat (3) tick();
    check("mid_after_level", level, 0);
    check("mid_after_total", total, 0);

    // 256 accepted captures wrap the counter back to zero.
    do_reset();
    res_ready = 1'b1; LD_outr = 1'b1;
    for (int i = 0; i < 256; i++) begin
      nxt = 4'(i); exp_q.push_back(4'(i));
      tick();
      check("wrap_ovf", ovf, 0);
    end
    LD_outr = 1'b0;
    repeat (3) tick();
    res_ready = 1'b0;
    check("wrap_total", total, 0);
    check("wrap_level", level, 0);
    check("wrap_ovf_end", ovf, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
